// File: rtl/dp_alu_sequencer.sv
// Multi-cycle sequencer for one ARM data-processing instruction through an external 32-bit ALU.
// Owns the NZCV register, evaluates the condition field, and issues Rd write-back and flag update.
module dp_alu_sequencer #(
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [3:0]  COND,
  input  logic [3:0]  OPCODE,
  input  logic        S_BIT,
  input  logic [3:0]  RD_IN,
  input  logic [31:0] RN_VAL,
  input  logic [31:0] OP2_VAL,
  input  logic        FLAGS_LOAD,
  input  logic [3:0]  FLAGS_IN,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_N,
  input  logic        ALU_Z,
  input  logic        ALU_C,
  input  logic        ALU_V,
  output logic [3:0]  ALU_FN,
  output logic [31:0] ALU_LEFT,
  output logic [31:0] ALU_RIGHT,
  output logic        ALU_CIN,
  output logic        RD_WE,
  output logic [3:0]  RD_ADDR,
  output logic [31:0] RD_DATA,
  output logic [3:0]  FLAGS,
  output logic        BUSY,
  output logic        DONE
);

  typedef enum logic [2:0] {IDLE, CHECK, EXEC, WB, SKIP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cond_q, cond_d;
  logic [3:0]  opcode_q, opcode_d;
  logic        s_bit_q, s_bit_d;
  logic [3:0]  rd_q, rd_d;
  logic [31:0] rn_q, rn_d;
  logic [31:0] op2_q, op2_d;
  logic [3:0]  flags_q, flags_d;
  logic [3:0]  alu_fn_q, alu_fn_d;
  logic [31:0] alu_left_q, alu_left_d;
  logic [31:0] alu_right_q, alu_right_d;
  logic        alu_cin_q, alu_cin_d;
  logic        rd_we_q, rd_we_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic is_test;
  logic is_arith;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c && !z;
      4'h9:    return !c || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // TST/TEQ/CMP/CMN never write Rd; SUB..RSC plus CMP/CMN produce their own C and V.
  assign is_test  = (opcode_q[3:2] == 2'b10);
  assign is_arith = (opcode_q inside {[4'h2:4'h7]}) || (opcode_q[3:1] == 3'b101);

  always_comb begin
    // NOTE: every *_d starts from its *_q (or an idle value) so no branch below can infer a latch.
    state_d     = state_q;
    cond_d      = cond_q;
    opcode_d    = opcode_q;
    s_bit_d     = s_bit_q;
    rd_d        = rd_q;
    rn_d        = rn_q;
    op2_d       = op2_q;
    flags_d     = flags_q;
    alu_fn_d    = alu_fn_q;
    alu_left_d  = alu_left_q;
    alu_right_d = alu_right_q;
    alu_cin_d   = alu_cin_q;
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    rd_we_d     = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (FLAGS_LOAD) flags_d = FLAGS_IN;
        if (START) begin
          cond_d   = COND;
          opcode_d = OPCODE;
          s_bit_d  = S_BIT;
          rd_d     = RD_IN;
          rn_d     = RN_VAL;
          op2_d    = OP2_VAL;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (cond_pass(cond_q, flags_q)) begin
          alu_fn_d    = opcode_q;
          alu_left_d  = rn_q;
          alu_right_d = op2_q;
          alu_cin_d   = flags_q[1];
          state_d     = EXEC;
        end else begin
          done_d  = 1'b1;
          state_d = SKIP;
        end
      end
      EXEC: begin
        // The ALU has had all of EXEC to settle; its result is registered straight into the write port.
        done_d  = 1'b1;
        state_d = WB;
        if (!is_test) begin
          rd_we_d   = 1'b1;
          rd_addr_d = rd_q;
          rd_data_d = ALU_RESULT;
        end
      end
      WB: begin
        state_d = IDLE;
        if (s_bit_q || is_test) begin
          flags_d[3] = is_test ? ALU_N : ALU_RESULT[31];
          flags_d[2] = is_test ? ALU_Z : (ALU_RESULT == 32'h0);
          if (is_arith) flags_d[1:0] = {ALU_C, ALU_V};
        end
      end
      SKIP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK) begin
    // NOTE: instruction capture regs are reset along with the outputs so no X ever reaches the ALU or Rd port.
    if (RESET) begin
      state_q     <= IDLE;
      cond_q      <= '0;
      opcode_q    <= '0;
      s_bit_q     <= 1'b0;
      rd_q        <= '0;
      rn_q        <= '0;
      op2_q       <= '0;
      flags_q     <= FLAGS_RST;
      alu_fn_q    <= '0;
      alu_left_q  <= '0;
      alu_right_q <= '0;
      alu_cin_q   <= 1'b0;
      rd_we_q     <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking only, so every flop samples the pre-edge value of every other flop.
      state_q     <= state_d;
      cond_q      <= cond_d;
      opcode_q    <= opcode_d;
      s_bit_q     <= s_bit_d;
      rd_q        <= rd_d;
      rn_q        <= rn_d;
      op2_q       <= op2_d;
      flags_q     <= flags_d;
      alu_fn_q    <= alu_fn_d;
      alu_left_q  <= alu_left_d;
      alu_right_q <= alu_right_d;
      alu_cin_q   <= alu_cin_d;
      rd_we_q     <= rd_we_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ALU_FN    = alu_fn_q;
  assign ALU_LEFT  = alu_left_q;
  assign ALU_RIGHT = alu_right_q;
  assign ALU_CIN   = alu_cin_q;
  assign RD_WE     = rd_we_q;
  assign RD_ADDR   = rd_addr_q;
  assign RD_DATA   = rd_data_q;
  assign FLAGS     = flags_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_dp_alu_sequencer.sv
// Self-checking bench for dp_alu_sequencer: golden ARM ALU on the ALU ports, directed cases,
// then randomized instructions checked against an instruction-level NZCV/Rd reference model.
module tb_dp_alu_sequencer;

  localparam logic [3:0] FLAGS_RST = 4'b0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  cond;
  logic [3:0]  opcode;
  logic        s_bit;
  logic [3:0]  rd_in;
  logic [31:0] rn_val;
  logic [31:0] op2_val;
  logic        flags_load;
  logic [3:0]  flags_in;
  logic [31:0] alu_result;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic [3:0]  alu_fn;
  logic [31:0] alu_left, alu_right;
  logic        alu_cin;
  logic        rd_we;
  logic [3:0]  rd_addr;
  logic [31:0] rd_data;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;
  logic [3:0] model_flags;

  dp_alu_sequencer #(.FLAGS_RST(FLAGS_RST)) dut (
    .CLK(clk), .RESET(reset), .START(start), .COND(cond), .OPCODE(opcode), .S_BIT(s_bit),
    .RD_IN(rd_in), .RN_VAL(rn_val), .OP2_VAL(op2_val), .FLAGS_LOAD(flags_load), .FLAGS_IN(flags_in),
    .ALU_RESULT(alu_result), .ALU_N(alu_n), .ALU_Z(alu_z), .ALU_C(alu_c), .ALU_V(alu_v),
    .ALU_FN(alu_fn), .ALU_LEFT(alu_left), .ALU_RIGHT(alu_right), .ALU_CIN(alu_cin),
    .RD_WE(rd_we), .RD_ADDR(rd_addr), .RD_DATA(rd_data), .FLAGS(flags), .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Golden ALU. Logical ops deliberately present a C/V that differs from the carry-in,
  // so a sequencer wrongly taking C/V from a logical op is visible.
  always_comb begin
    logic [32:0] sum;
    logic [31:0] x, y;
    logic        k, arith;
    sum = '0; x = '0; y = '0; k = 1'b0; arith = 1'b0;
    alu_result = '0;
    alu_c = !alu_cin;
    alu_v = 1'b1;
    case (alu_fn)
      4'h0, 4'h8: alu_result = alu_left & alu_right;
      4'h1, 4'h9: alu_result = alu_left ^ alu_right;
      4'hC:       alu_result = alu_left | alu_right;
      4'hD:       alu_result = alu_right;
      4'hE:       alu_result = alu_left & ~alu_right;
      4'hF:       alu_result = ~alu_right;
      4'h2, 4'hA: begin x = alu_left;  y = ~alu_right; k = 1'b1;    arith = 1'b1; end
      4'h3:       begin x = alu_right; y = ~alu_left;  k = 1'b1;    arith = 1'b1; end
      4'h4, 4'hB: begin x = alu_left;  y = alu_right;  k = 1'b0;    arith = 1'b1; end
      4'h5:       begin x = alu_left;  y = alu_right;  k = alu_cin; arith = 1'b1; end
      4'h6:       begin x = alu_left;  y = ~alu_right; k = alu_cin; arith = 1'b1; end
      default:    begin x = alu_right; y = ~alu_left;  k = alu_cin; arith = 1'b1; end
    endcase
    if (arith) begin
      sum        = {1'b0, x} + {1'b0, y} + {32'h0, k};
      alu_result = sum[31:0];
      alu_c      = sum[32];
      alu_v      = (x[31] == y[31]) && (sum[31] != x[31]);
    end
    alu_n = alu_result[31];
    alu_z = (alu_result == 32'h0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'h0: return z;            4'h1: return !z;
      4'h2: return cy;           4'h3: return !cy;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return cy && !z;     4'h9: return !cy || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;         default: return 1'b0;
    endcase
  endfunction

  // Reference arithmetic in wide integers: carry = unsigned result out of range (or no borrow),
  // overflow = signed result out of 32-bit range.
  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input bit cin, output logic [31:0] r, output bit c, output bit v,
                                  output bit arith);
    longint ux, uy, sx, sy, u, s;
    bit sub, swap;
    longint k;
    arith = 1'b1; c = 1'b0; v = 1'b0; r = '0;
    sub = 1'b0; swap = 1'b0; k = 0;
    case (op)
      4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
      4'hC:       begin r = a | b;  arith = 1'b0; end
      4'hD:       begin r = b;      arith = 1'b0; end
      4'hE:       begin r = a & ~b; arith = 1'b0; end
      4'hF:       begin r = ~b;     arith = 1'b0; end
      4'h2, 4'hA: sub = 1'b1;
      4'h3:       begin sub = 1'b1; swap = 1'b1; end
      4'h4, 4'hB: k = 0;
      4'h5:       k = cin ? 1 : 0;
      4'h6:       begin sub = 1'b1; k = cin ? 0 : 1; end
      default:    begin sub = 1'b1; swap = 1'b1; k = cin ? 0 : 1; end
    endcase
    if (arith) begin
      ux = swap ? b : a;
      uy = swap ? a : b;
      sx = swap ? $signed(b) : $signed(a);
      sy = swap ? $signed(a) : $signed(b);
      if (sub) begin
        u = ux - uy - k; s = sx - sy - k; c = (u >= 0);
      end else begin
        u = ux + uy + k; s = sx + sy + k; c = (u > 64'sd4294967295);
      end
      v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      r = u[31:0];
    end
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Issue one instruction at a negedge while idle; return at the first negedge with BUSY low.
  // junk=1 also pulses FLAGS_LOAD during CHECK and START during EXEC/SKIP, both to be ignored.
  task automatic run_instr(input logic [3:0] c, input logic [3:0] op, input logic s,
                           input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2,
                           input logic fl_ld, input logic [3:0] fl_in, input bit junk);
    logic [31:0] r, got_data, g_left, g_right;
    logic [3:0]  got_addr, g_fn;
    logic        g_cin;
    bit pass, cy, ov, arith, test, exp_we;
    int done_cnt, done_cyc, we_cnt, we_cyc, end_cyc;

    if (fl_ld) model_flags = fl_in;
    pass   = cond_ok(c, model_flags);
    test   = (op[3:2] == 2'b10);
    exp_we = pass && !test;
    ref_alu(op, rn, op2, model_flags[1], r, cy, ov, arith);

    start = 1'b1; cond = c; opcode = op; s_bit = s; rd_in = rd;
    rn_val = rn; op2_val = op2; flags_load = fl_ld; flags_in = fl_in;
    @(posedge clk);

    done_cnt = 0; done_cyc = 0; we_cnt = 0; we_cyc = 0; end_cyc = 0;
    got_data = '0; got_addr = '0; g_fn = '0; g_left = '0; g_right = '0; g_cin = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (done)  begin done_cnt++; done_cyc = k; end
      if (rd_we) begin we_cnt++; we_cyc = k; got_data = rd_data; got_addr = rd_addr; end
      if (k == 1) begin
        check("busy_after_start", busy, 1'b1);
        start = 1'b0;
        flags_load = junk;
        flags_in = ~model_flags;
      end
      if (k == 2) begin
        g_fn = alu_fn; g_left = alu_left; g_right = alu_right; g_cin = alu_cin;
        flags_load = 1'b0;
        if (junk) begin
          start = 1'b1; cond = 4'hE; opcode = 4'h4; s_bit = 1'b1; rd_in = ~rd;
          rn_val = $urandom; op2_val = $urandom;
        end
      end
      if (k == 3) start = 1'b0;
      if (!busy) begin end_cyc = k; break; end
    end

    if (pass && (s || test)) begin
      model_flags[3] = r[31];
      model_flags[2] = (r == 32'h0);
      if (arith) model_flags[1:0] = {cy, ov};
    end

    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, pass ? 3 : 2);
    check("busy_fall_cycle", end_cyc, pass ? 4 : 3);
    check("rd_we_count", we_cnt, exp_we ? 1 : 0);
    if (exp_we) begin
      check("rd_we_cycle", we_cyc, 3);
      check("rd_addr", got_addr, rd);
      check("rd_data", got_data, r);
    end
    if (pass) begin
      check("alu_fn", g_fn, op);
      check("alu_left", g_left, rn);
      check("alu_right", g_right, op2);
      check("alu_cin", g_cin, fl_ld ? fl_in[1] : g_cin ^ 1'b0 ^ (g_cin ^ model_cin_snapshot(fl_ld, fl_in)));
    end
    check("flags", flags, model_flags);
  endtask

  // Carry-in the instruction must have seen, recorded by issue_cin before issue.
  logic issue_cin;
  function automatic logic model_cin_snapshot(input logic fl_ld, input logic [3:0] fl_in);
    return fl_ld ? fl_in[1] : issue_cin;
  endfunction

  task automatic issue(input logic [3:0] c, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] rn, input logic [31:0] op2,
                       input logic fl_ld, input logic [3:0] fl_in, input bit junk);
    issue_cin = model_flags[1];
    run_instr(c, op, s, rd, rn, op2, fl_ld, fl_in, junk);
  endtask

  task automatic reset_in_exec();
    int strobes;
    issue_cin = 1'b1;
    start = 1'b1; cond = 4'hE; opcode = 4'h4; s_bit = 1'b1; rd_in = 4'h9;
    rn_val = 32'h1234_5678; op2_val = 32'h1111_1111; flags_load = 1'b1; flags_in = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; flags_load = 1'b0;
    @(negedge clk);
    check("rst_pre_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_we", rd_we, 1'b0);
    check("rst_flags", flags, FLAGS_RST);
    check("rst_alu_fn", alu_fn, 4'h0);
    check("rst_alu_left", alu_left, 32'h0);
    check("rst_alu_cin", alu_cin, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    reset = 1'b0;
    model_flags = FLAGS_RST;
    strobes = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rd_we || done || busy) strobes++;
    end
    check("rst_no_aftermath", strobes, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cond = '0; opcode = '0; s_bit = 1'b0; rd_in = '0;
    rn_val = '0; op2_val = '0; flags_load = 1'b0; flags_in = '0; issue_cin = 1'b0;
    model_flags = FLAGS_RST;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_flags", flags, FLAGS_RST);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rd_we", rd_we, 1'b0);
    check("reset_rd_addr", rd_addr, 4'h0);
    check("reset_rd_data", rd_data, 32'h0);
    check("reset_alu_fn", alu_fn, 4'h0);
    check("reset_alu_right", alu_right, 32'h0);
    reset = 1'b0;

    issue(4'hE, 4'h4, 1'b1, 4'h1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h0, 1'b0);
    check("add_carry_flags", flags, 4'b0110);
    issue(4'hE, 4'h5, 1'b0, 4'h2, 32'd5, 32'd3, 1'b0, 4'h0, 1'b0);
    check("adc_flags_kept", flags, 4'b0110);
    issue(4'h0, 4'h2, 1'b1, 4'h3, 32'd7, 32'd7, 1'b1, 4'b0000, 1'b0);
    check("subeq_skip_flags", flags, 4'b0000);
    issue(4'hE, 4'hA, 1'b0, 4'h4, 32'd3, 32'd5, 1'b0, 4'h0, 1'b0);
    check("cmp_flags", flags, 4'b1000);
    issue(4'hE, 4'hD, 1'b1, 4'h5, 32'hDEAD_BEEF, 32'h0, 1'b1, 4'b0011, 1'b0);
    check("mov_keeps_cv", flags, 4'b0111);
    issue(4'hE, 4'h4, 1'b0, 4'h6, 32'd10, 32'd20, 1'b0, 4'h0, 1'b1);
    issue(4'hF, 4'h4, 1'b1, 4'h7, 32'd1, 32'd1, 1'b0, 4'h0, 1'b1);
    reset_in_exec();

    for (int i = 0; i < 300; i++) begin
      issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), pick_val(), pick_val(),
            ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dp_alu_sequencer.md
Name: dp_alu_sequencer

Overview:
Multi-cycle controller that sequences one ARM data-processing instruction through the 32-bit ALU (FN encoding = ARM opcode, AND=0000 … MVN=1111).
It owns the NZCV flags register and evaluates the condition field against it.
It drives the ALU operands, FN and CIN, captures the result, and issues the Rd write-back and the flag update.
It sits between the decode stage (START handshake) and the register file write port.

Parameters:
FLAGS_RST, 4'b0000, reset value of the NZCV register (bit3=N, bit2=Z, bit1=C, bit0=V).

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  decode requests an instruction; accepted only in IDLE
COND  in  4  ARM condition field
OPCODE  in  4  ARM DP opcode, passed to ALU as FN
S_BIT  in  1  flag-update request
RD_IN  in  4  destination register number
RN_VAL  in  32  first operand (ALU left)
OP2_VAL  in  32  shifted operand 2 (ALU right)
FLAGS_LOAD  in  1  direct load of NZCV (MSR-style)
FLAGS_IN  in  4  NZCV value for FLAGS_LOAD
ALU_RESULT  in  32  ALU output
ALU_N, ALU_Z, ALU_C, ALU_V  in  1 each  ALU flag outputs
ALU_FN  out  4  FN to ALU
ALU_LEFT, ALU_RIGHT  out  32 each  ALU operands
ALU_CIN  out  1  carry-in to ALU
RD_WE  out  1  register-file write strobe, one-cycle pulse
RD_ADDR  out  4  write address
RD_DATA  out  32  write data
FLAGS  out  4  current NZCV register
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, CHECK, EXEC, WB, SKIP.
- Reset (any state, mid-operation included) returns to IDLE with the following values:
  - FLAGS=FLAGS_RST
  - all other outputs 0: ALU_FN, ALU_LEFT, ALU_RIGHT, ALU_CIN, RD_WE, RD_ADDR, RD_DATA, BUSY, DONE
  - no write or flag update for an aborted instruction
- IDLE, START=1:
  - latch COND, OPCODE, S_BIT, RD_IN, RN_VAL, OP2_VAL into internal registers
  - go to CHECK
- IDLE, FLAGS_LOAD=1: FLAGS<=FLAGS_IN. If START is asserted the same cycle, the load happens first and CHECK sees the loaded flags.
- FLAGS_LOAD is ignored outside IDLE. START is ignored outside IDLE; decode must hold it until it sees BUSY=0.
- CHECK evaluates the latched COND against FLAGS:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL 1; 1111 (NV) treated as never
  - pass -> EXEC; fail -> SKIP
- EXEC:
  - ALU_FN=latched OPCODE, ALU_LEFT=RN_VAL, ALU_RIGHT=OP2_VAL, ALU_CIN=FLAGS[1], all registered
  - held stable through WB
  - one full cycle for the combinational ALU to settle; go to WB
- WB: DONE=1, then return to IDLE.
- WB, writing ops (OPCODE not 10xx): RD_WE=1, RD_ADDR=latched RD_IN, RD_DATA=ALU_RESULT.
- WB, test ops (TST/TEQ/CMP/CMN, OPCODE 10xx): RD_WE=0. Flags are always updated, regardless of S_BIT.
- Flag update (at the end of WB, when S_BIT=1 or a test op):
  - N=ALU_RESULT[31] for writing ops; N=ALU_N for test ops
  - Z=(ALU_RESULT==0) for writing ops; Z=ALU_Z for test ops
  - C and V: arithmetic ops (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN) take ALU_C/ALU_V; all logical ops retain the old C and V
- Flag update when S_BIT=0 on a writing op: FLAGS unchanged.
- SKIP: DONE=1, RD_WE=0, FLAGS unchanged, return to IDLE.
- Latency from START accepted (cycle 0):
  - condition pass: DONE/RD_WE in cycle 3; BUSY falls in cycle 4
  - condition fail: DONE in cycle 2
- Back-to-back: START can be accepted in the first IDLE cycle after DONE.
- RD_WE and DONE are never high outside WB/SKIP.

Test Plan:
- The bench uses a golden ARM-correct ALU model connected to the ALU ports.
- ADD AL S=1, RN=0xFFFFFFFF, OP2=0x00000001 -> cycle 3: RD_WE=1, RD_DATA=0x00000000; then FLAGS=4'b0110.
- Following ADC AL S=0, RN=5, OP2=3 (C=1) -> ALU_CIN=1, RD_DATA=0x00000009, FLAGS stay 4'b0110.
- FLAGS_LOAD=1, FLAGS_IN=4'b0000 with START (SUBEQ, RN=7, OP2=7) the same cycle -> CHECK fails, DONE in cycle 2, RD_WE never high, FLAGS=4'b0000.
- CMP AL S=0, RN=3, OP2=5 -> RD_WE stays 0, FLAGS=4'b1000 (N=1, C=0 borrow); DONE in cycle 3.
- MOV AL S=1, OP2=0, with prior C=1, V=1 -> RD_DATA=0, FLAGS=4'b0111 (C/V retained).
- START pulsed during EXEC is ignored (no second DONE).
- RESET asserted in EXEC -> next cycle IDLE, BUSY=0, FLAGS=FLAGS_RST, no RD_WE.
